pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, meaning max MEM_WAIT cycles before mem_err sets (range 1..65535).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports idex_memread in 1 (load in EX) and idex_rt in 5 (load destination register).
REQ-005 SHALL have ports ifid_rs in 5, ifid_rt in 5 and ifid_uses_rt in 1 (ID source registers; rt is a real source).
REQ-006 SHALL have port branch_taken  in  1  taken branch/jump resolved in EX; held by the datapath while EX is frozen.
REQ-007 SHALL have ports mem_req in 1 (EX/MEM instruction accesses data memory) and mem_ready in 1 (memory access completes this cycle).
REQ-008 SHALL have outputs pc_en, ifid_en, idex_en, exmem_en and memwb_en, each out 1: stage-register load enables.
REQ-009 SHALL have outputs ifid_flush, idex_bubble and memwb_bubble, each out 1: load NOP/zeroed control into that register.
REQ-010 SHALL have outputs state out 2 (FSM state), stall_count out 16 (saturating count of cycles with pc_en=0) and mem_err out 1 (sticky timeout flag).

Function
REQ-011 SHALL implement FSM states RUN=0, LU_STALL=1 and MEM_WAIT=2; code 3 is illegal and SHALL go to RUN on the next edge.
REQ-012 SHALL assert load-use hazard lu_hit = idex_memread & idex_rt!=0 & (idex_rt==ifid_rs | (ifid_uses_rt & idex_rt==ifid_rt)).
REQ-013 SHALL assert mem_stall = mem_req & ~mem_ready.
REQ-014 SHALL decode outputs combinationally from state and inputs (Mealy), with priority mem_stall > branch_taken > lu_hit.
REQ-015 SHALL, when mem_stall=1: drive pc_en, ifid_en, idex_en and exmem_en to 0; memwb_en=1; memwb_bubble=1; flush and idex_bubble to 0; next state MEM_WAIT.
REQ-016 SHALL, when mem_stall=0 and branch_taken=1: drive all enables to 1, ifid_flush=1 and idex_bubble=1; next state RUN; a simultaneous lu_hit is ignored.
REQ-017 SHALL, in RUN with lu_hit=1 and no higher-priority event: drive pc_en=0 and ifid_en=0, other enables 1, idex_bubble=1; next state LU_STALL.
REQ-018 SHALL spend exactly one cycle in LU_STALL with lu_hit masked: all enables 1, no bubbles, next state RUN, unless mem_stall or branch_taken applies per REQ-015/016.
REQ-019 SHALL, in MEM_WAIT with mem_ready=1: drive all enables 1 with no bubbles (held branch_taken applies per REQ-016); next state RUN.
REQ-020 SHALL, with no event: drive all enables 1 and all flush/bubble outputs 0; state stays RUN.
REQ-021 SHALL clear an internal 16-bit wait_cnt on entering MEM_WAIT and increment it each cycle in MEM_WAIT.
REQ-022 SHALL set mem_err when wait_cnt reaches MEM_TIMEOUT; mem_err stays set until rst, and the FSM keeps waiting.
REQ-023 SHALL increment stall_count on every clock edge where pc_en=0 (reset cycles excluded), saturating at 16'hFFFF with no wrap.
REQ-024 SHALL give zero added latency: every output responds in the same cycle as its inputs.

Reset
REQ-025 SHALL, while rst=1, force all enables to 0 and ifid_flush, idex_bubble and memwb_bubble to 1, independent of clk.
REQ-026 SHALL, on rst=1, set state=RUN, wait_cnt=0, stall_count=0 and mem_err=0 asynchronously.
REQ-027 SHALL, if reset is asserted mid-stall or mid-MEM_WAIT, abandon the operation; on the first edge after release behave per RUN.

Structure
REQ-028 SHALL define in shared package pipeline_pkg: state encodings, REG_W=5, ZERO_REG=5'd0 and the stall_count width.
REQ-029 SHALL place the REQ-012 comparison in combinational sub-module load_use_detect; FSM, counters and output decode remain in pipeline_ctrl.

Verification
REQ-030 SHALL test load-use: idex_memread=1, idex_rt=8, ifid_rs=8 -> pc_en=0, ifid_en=0, idex_bubble=1 for one cycle; state goes 1 then 0; stall_count=1.
REQ-031 SHALL test the $zero exception: idex_memread=1, idex_rt=0, ifid_rs=0 -> no stall, state stays 0.
REQ-032 SHALL test memory wait: mem_req=1 with mem_ready low for 3 cycles -> pc/ifid/idex/exmem_en=0 and memwb_bubble=1 for 3 cycles, state=2; on mem_ready=1 all enables 1; stall_count=3.
REQ-033 SHALL test timeout: MEM_TIMEOUT=4 with mem_ready held low for 6 cycles -> mem_err=1 after the 4th MEM_WAIT cycle, held after mem_ready=1 until rst.
REQ-034 SHALL test branch plus hazard: branch_taken=1 with lu_hit true -> pc_en=1, ifid_flush=1, idex_bubble=1, state stays 0.
REQ-035 SHALL test async reset in MEM_WAIT: rst pulse between edges -> outputs per REQ-025 immediately; state=0, stall_count=0, mem_err=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared encodings and widths for the pipeline hazard controller.
// Latency/backpressure: none (declarations only).
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  localparam int STALL_CNT_W = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Flags a load in EX whose destination feeds an ID source register; $zero never hazards.
// Latency: 0 cycles (pure combinational); no backpressure of its own.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  output logic             lu_hit
);

  assign lu_hit = idex_memread && (idex_rt != ZERO_REG) &&
                  ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller: stage enables, flushes and bubbles for a 5-stage pipeline.
// Latency: 0 cycles (Mealy decode); memory not-ready freezes PC..EX/MEM and bubbles MEM/WB.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
)
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   idex_memread,
  input  logic [REG_W-1:0]       idex_rt,
  input  logic [REG_W-1:0]       ifid_rs,
  input  logic [REG_W-1:0]       ifid_rt,
  input  logic                   ifid_uses_rt,
  input  logic                   branch_taken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   idex_en,
  output logic                   exmem_en,
  output logic                   memwb_en,
  output logic                   ifid_flush,
  output logic                   idex_bubble,
  output logic                   memwb_bubble,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   mem_err
);

  state_t      st_q;
  state_t      st_d;
  logic        lu_hit;
  logic        mem_stall;
  logic [15:0] wait_cnt;
  logic [16:0] wait_cnt_inc;

  load_use_detect u_load_use_detect (
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rt (ifid_uses_rt),
    .lu_hit       (lu_hit)
  );

  assign mem_stall    = mem_req & ~mem_ready;
  assign wait_cnt_inc = {1'b0, wait_cnt} + 17'd1;
  assign state        = st_q;

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    st_d         = RUN;
    if (rst) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end else begin
      case (st_q)
        RUN, LU_STALL, MEM_WAIT: begin
          if (mem_stall) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            st_d         = MEM_WAIT;
          end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if ((st_q == RUN) && lu_hit) begin
            // Hazard is only acted on from RUN; the stall cycle itself masks it.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            st_d        = LU_STALL;
          end
        end
        default: st_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= RUN;
      wait_cnt    <= '0;
      stall_count <= '0;
      mem_err     <= 1'b0;
    end else begin
      st_q <= st_d;
      if (st_q == MEM_WAIT) begin
        if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
        // Sticky: the FSM keeps waiting, software sees the timeout until reset.
        if (wait_cnt_inc >= 17'(MEM_TIMEOUT)) mem_err <= 1'b1;
      end else if (st_d == MEM_WAIT) begin
        wait_cnt <= '0;
      end
      if (!pc_en && (stall_count != STALL_CNT_MAX)) stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed hazard scenarios, then random traffic.
module tb_pipeline_ctrl;
  import pipeline_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        idex_memread = 1'b0;
  logic [4:0]  idex_rt = '0;
  logic [4:0]  ifid_rs = '0;
  logic [4:0]  ifid_rt = '0;
  logic        ifid_uses_rt = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_bubble, memwb_bubble;
  logic [1:0]  state;
  logic [15:0] stall_count;
  logic        mem_err;

  pipeline_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
    .state(state), .stall_count(stall_count), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mr;
    logic [4:0] rt;
    logic [4:0] rs;
    logic [4:0] rt2;
    logic       urt;
    logic       br;
    logic       mq;
    logic       rdy;
  } in_t;

  // ctl = {pc,ifid,idex,exmem,memwb enables, ifid_flush, idex_bubble, memwb_bubble}
  typedef struct packed {
    logic [7:0]  ctl;
    logic [1:0]  st;
    logic [15:0] sc;
    logic        err;
  } exp_t;

  exp_t expq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: pipeline mode (0 run, 1 just stalled for load-use, 2 waiting on memory)
  int   m_mode = 0;
  int   m_stalls = 0;
  int   m_wait_cycles = 0;
  bit   m_err = 1'b0;

  function automatic in_t mk(bit mr, int rt, int rs, int rt2, bit urt, bit br, bit mq, bit rdy);
    in_t s;
    s.mr = mr; s.rt = 5'(rt); s.rs = 5'(rs); s.rt2 = 5'(rt2);
    s.urt = urt; s.br = br; s.mq = mq; s.rdy = rdy;
    return s;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.ctl = 8'b00000_111; e.st = 2'd0; e.sc = 16'd0; e.err = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_stalls = 0; m_wait_cycles = 0; m_err = 1'b0;
  endtask

  // Expected outputs for the current cycle, then advance the model across the next edge.
  task automatic model_cycle(input in_t s, output exp_t e);
    bit ms, lu;
    int nxt;
    logic [7:0] c;
    ms = s.mq && !s.rdy;
    lu = s.mr && (s.rt != 0) && ((s.rt == s.rs) || (s.urt && (s.rt == s.rt2)));
    if (ms)                     begin c = 8'b00001_001; nxt = 2; end
    else if (s.br)              begin c = 8'b11111_110; nxt = 0; end
    else if (m_mode == 0 && lu) begin c = 8'b00111_010; nxt = 1; end
    else                        begin c = 8'b11111_000; nxt = 0; end
    e.ctl = c; e.st = 2'(m_mode); e.sc = 16'(m_stalls); e.err = m_err;
    if (!c[7] && m_stalls < 65535) m_stalls++;
    if (m_mode == 2) begin
      m_wait_cycles++;
      if (m_wait_cycles >= TMO) m_err = 1'b1;
    end else if (nxt == 2) begin
      m_wait_cycles = 0;
    end
    m_mode = nxt;
  endtask

  // mode: 0 normal cycle, 1 reset held through the cycle, 2 reset pulse between edges
  task automatic run_cycle(input in_t s, input int mode);
    exp_t e;
    @(posedge clk);
    #2;
    idex_memread = s.mr; idex_rt = s.rt; ifid_rs = s.rs; ifid_rt = s.rt2;
    ifid_uses_rt = s.urt; branch_taken = s.br; mem_req = s.mq; mem_ready = s.rdy;
    if (mode == 1) begin
      rst = 1'b1;
      model_reset();
      expq.push_back(reset_exp());
    end else if (mode == 2) begin
      rst = 1'b1;
      model_reset();
      expq.push_back(reset_exp());
      #4;
      rst = 1'b0;
      model_cycle(s, e);  // the edge after release acts on these inputs from RUN
    end else begin
      rst = 1'b0;
      model_cycle(s, e);
      expq.push_back(e);
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("ctl", {8'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_flush, idex_bubble, memwb_bubble}, {8'd0, e.ctl});
        chk("state", {14'd0, state}, {14'd0, e.st});
        chk("stall_count", stall_count, e.sc);
        chk("mem_err", {15'd0, mem_err}, {15'd0, e.err});
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    in_t idle;
    in_t s;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) run_cycle(idle, 1);
    for (int k = 0; k < 2; k++) run_cycle(idle, 0);

    // load-use on rs, then same instruction pair seen again while masked
    s = mk(1, 8, 8, 0, 0, 0, 0, 0);
    run_cycle(s, 0);
    run_cycle(s, 0);
    run_cycle(idle, 0);
    // $zero destination never stalls
    s = mk(1, 0, 0, 0, 1, 0, 0, 0);
    run_cycle(s, 0);
    run_cycle(s, 0);
    // rt hazard only when rt is a real source
    run_cycle(mk(1, 5, 1, 5, 0, 0, 0, 0), 0);
    run_cycle(mk(1, 5, 1, 5, 1, 0, 0, 0), 0);
    run_cycle(idle, 0);

    // memory wait of three cycles, then ready
    s = mk(0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) run_cycle(s, 0);
    run_cycle(mk(0, 0, 0, 0, 0, 0, 1, 1), 0);
    run_cycle(idle, 0);

    // timeout: six not-ready cycles, error sticks afterwards
    for (int k = 0; k < 6; k++) run_cycle(s, 0);
    run_cycle(mk(0, 0, 0, 0, 0, 0, 1, 1), 0);
    for (int k = 0; k < 3; k++) run_cycle(idle, 0);

    // branch outranks a simultaneous load-use hazard
    run_cycle(mk(1, 8, 8, 0, 0, 1, 0, 0), 0);
    run_cycle(idle, 0);

    // async reset pulse while waiting on memory
    for (int k = 0; k < 2; k++) run_cycle(s, 0);
    run_cycle(s, 2);
    run_cycle(idle, 0);
    run_cycle(idle, 0);

    for (int k = 0; k < 800; k++) begin
      s = mk($urandom_range(0, 9) < 4, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 2,
             $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1);
      run_cycle(s, ($urandom_range(0, 49) == 0) ? 2 : 0);
    end

    @(posedge clk);
    @(posedge clk);
    chk("drain", 16'(expq.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
